// File: rtl/mem_access_responder.sv
// mem_access_responder: AR-latched single-word SRAM responder with fixed wait states and a one-deep pending slot.
// Define MEM_PARITY_EN to add an even-parity bit on the SRAM data buses and the parity_error output.
module mem_access_responder #(
    parameter int word_size   = 32,
    parameter int addr_size   = 10,
    parameter int mem_depth   = 1024,
    parameter int wait_cycles = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_ar,
    input  logic [word_size-1:0] addr_in,
    input  logic                 load_mem,
    input  logic                 store_mem,
    input  logic [word_size-1:0] data_in,
    output logic [word_size-1:0] data_out,
    output logic                 data_valid,
    output logic                 write_done,
    output logic                 busy,
    output logic                 bus_error,
    output logic                 overrun,
    output logic                 sram_ce,
    output logic                 sram_we,
    output logic [addr_size-1:0] sram_addr,
`ifdef MEM_PARITY_EN
    output logic [word_size:0]   sram_wdata,
    input  logic [word_size:0]   sram_rdata,
    output logic                 parity_error
`else
    output logic [word_size-1:0] sram_wdata,
    input  logic [word_size-1:0] sram_rdata
`endif
);
    localparam logic [1:0] st_idle = 2'd0, st_setup = 2'd1, st_wait = 2'd2, st_complete = 2'd3;

    logic [1:0]           state, next_state;
    logic [3:0]           cnt;
    logic [word_size-1:0] ar, eff_addr, cur_data, pend_data, l_data;
    logic [addr_size-1:0] cur_addr, pend_addr, l_addr;
    logic                 cur_we, cur_oor, pend_we, pend_oor, pend_valid;
    logic                 req, req_oor, can_launch, launch, to_pend, drop, last_cycle, l_we, l_oor;
`ifdef MEM_PARITY_EN
    logic                 perr;
`endif

    assign req        = load_mem | store_mem;
    assign eff_addr   = load_ar ? addr_in : ar;
    assign req_oor    = eff_addr >= word_size'(mem_depth);
    assign can_launch = state == st_idle || state == st_complete;
    // A waiting request always goes first; a new one only launches directly when the slot is empty.
    assign launch     = can_launch && (pend_valid || req);
    assign to_pend    = req && !can_launch && !pend_valid;
    assign drop       = req && pend_valid;
    assign l_we       = pend_valid ? pend_we   : store_mem;
    assign l_oor      = pend_valid ? pend_oor  : req_oor;
    assign l_addr     = pend_valid ? pend_addr : eff_addr[addr_size-1:0];
    assign l_data     = pend_valid ? pend_data : data_in;
    assign last_cycle = (state == st_setup && wait_cycles == 0) ||
                        (state == st_wait && cnt == 4'(wait_cycles - 1));

    assign next_state = launch                ? (l_oor ? st_complete : st_setup)
                      : state == st_setup     ? (wait_cycles == 0 ? st_complete : st_wait)
                      : state == st_wait      ? (last_cycle ? st_complete : st_wait)
                      : state == st_complete  ? st_idle
                      : state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= st_idle;
            cnt        <= '0;
            ar         <= '0;
            cur_we     <= 1'b0;
            cur_oor    <= 1'b0;
            cur_addr   <= '0;
            cur_data   <= '0;
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_oor   <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            data_out   <= '0;
            overrun    <= 1'b0;
`ifdef MEM_PARITY_EN
            perr       <= 1'b0;
`endif
        end else begin
            state <= next_state;
            cnt   <= state == st_wait ? cnt + 4'd1 : 4'd0;
            if (load_ar)
                ar <= addr_in;
            if (launch) begin
                cur_we   <= l_we;
                cur_oor  <= l_oor;
                cur_addr <= l_addr;
                cur_data <= l_data;
            end
            if (launch && l_oor && !l_we) begin
                data_out <= '0;
`ifdef MEM_PARITY_EN
                perr     <= 1'b0;
`endif
            end else if (last_cycle && !cur_we) begin
                data_out <= sram_rdata[word_size-1:0];
`ifdef MEM_PARITY_EN
                perr     <= sram_rdata[word_size] != ^sram_rdata[word_size-1:0];
`endif
            end
            if (launch && pend_valid)
                pend_valid <= 1'b0;
            else if (to_pend) begin
                pend_valid <= 1'b1;
                pend_we    <= store_mem;
                pend_oor   <= req_oor;
                pend_addr  <= eff_addr[addr_size-1:0];
                pend_data  <= data_in;
            end
            if (drop || (load_mem && store_mem))
                overrun <= 1'b1;
        end
    end

    assign sram_ce    = state == st_setup || state == st_wait;
    assign sram_we    = sram_ce && cur_we;
    assign sram_addr  = sram_ce ? cur_addr : '0;
    assign data_valid = state == st_complete && !cur_we;
    assign write_done = state == st_complete && cur_we;
    assign bus_error  = state == st_complete && cur_oor;
    assign busy       = state != st_idle || pend_valid;
`ifdef MEM_PARITY_EN
    assign sram_wdata   = sram_we ? {^cur_data, cur_data} : '0;
    assign parity_error = data_valid && perr;
`else
    assign sram_wdata   = sram_we ? cur_data : '0;
`endif
endmodule

// File: tb/tb_mem_access_responder.sv
// tb_mem_access_responder: directed bench with a timeline/queue model of request service, plus literal spot checks.
module tb_mem_access_responder;
    localparam int WAITS = 2;
    localparam int NC    = 1024;
`ifdef MEM_PARITY_EN
    localparam int BW = 33;
`else
    localparam int BW = 32;
`endif

    logic          clock = 1'b0;
    logic          reset, load_ar, load_mem, store_mem;
    logic [31:0]   addr_in, data_in, data_out, dout0;
    logic          data_valid, write_done, busy, bus_error, overrun, sram_ce, sram_we;
    logic          dv0, wd0, busy0, be0, ovr0, ce0, we0;
    logic [9:0]    sram_addr, addr0;
    logic [BW-1:0] sram_wdata, sram_rdata, wdata0;
    logic [BW-1:0] rdata0 = '0;
    logic [BW-1:0] sram_mem [1024];
`ifdef MEM_PARITY_EN
    logic          parity_error, pe0;
    logic [BW-1:0] flip_mask = '0;
    assign sram_rdata = sram_mem[sram_addr] ^ flip_mask;
`else
    assign sram_rdata = sram_mem[sram_addr];
`endif

    always #5 clock = ~clock;
    always @(posedge clock) if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;

    mem_access_responder #(.word_size(32), .addr_size(10), .mem_depth(1024), .wait_cycles(WAITS)) dut (
        .clock(clock), .reset(reset), .load_ar(load_ar), .addr_in(addr_in), .load_mem(load_mem),
        .store_mem(store_mem), .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .write_done(write_done), .busy(busy), .bus_error(bus_error), .overrun(overrun),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
`ifdef MEM_PARITY_EN
        .sram_rdata(sram_rdata), .parity_error(parity_error)
`else
        .sram_rdata(sram_rdata)
`endif
    );

    mem_access_responder #(.word_size(32), .addr_size(10), .mem_depth(1024), .wait_cycles(0)) dut0 (
        .clock(clock), .reset(reset), .load_ar(load_ar), .addr_in(addr_in), .load_mem(load_mem),
        .store_mem(store_mem), .data_in(data_in), .data_out(dout0), .data_valid(dv0),
        .write_done(wd0), .busy(busy0), .bus_error(be0), .overrun(ovr0),
        .sram_ce(ce0), .sram_we(we0), .sram_addr(addr0), .sram_wdata(wdata0),
`ifdef MEM_PARITY_EN
        .sram_rdata(rdata0), .parity_error(pe0)
`else
        .sram_rdata(rdata0)
`endif
    );

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h9E3779B9 + 32'h1234;
    endfunction

    function automatic logic [BW-1:0] wide(input logic [31:0] d);
`ifdef MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Model: requests are served strictly in acceptance order, each one starting the cycle
    // after both its acceptance and the previous completion; a request is dropped while an
    // accepted one has not started yet.
    bit          e_busy[NC], e_ce[NC], e_we[NC], e_dv[NC], e_wd[NC], e_be[NC], e_pe[NC];
    logic [9:0]    e_ad[NC];
    logic [BW-1:0] e_wv[NC];
    logic [31:0]   e_rd[NC];
    logic [31:0]   mdl_mem[1024];
    logic [31:0]   m_data, m_ar;
    bit            m_ovr;
    int            last_start = -1, last_done = -1;

    task automatic accept();
        int st, dn;
        logic [31:0] a;
        logic oor;
        if (load_mem && store_mem) m_ovr = 1;
        if (last_start > cyc) begin
            m_ovr = 1;
            return;
        end
        a   = load_ar ? addr_in : m_ar;
        oor = a >= 1024;
        st  = (cyc + 1 > last_done + 1) ? cyc + 1 : last_done + 1;
        dn  = oor ? st : st + 1 + WAITS;
        for (int i = cyc + 1; i <= dn; i++) e_busy[i] = 1;
        if (!oor)
            for (int i = st; i < dn; i++) begin
                e_ce[i] = 1; e_ad[i] = a[9:0]; e_we[i] = store_mem; e_wv[i] = wide(data_in);
            end
        e_be[dn] = oor;
        if (store_mem) begin
            e_wd[dn] = 1;
            if (!oor) mdl_mem[a[9:0]] = data_in;
        end else begin
            e_dv[dn] = 1;
            e_rd[dn] = oor ? 32'h0 : mdl_mem[a[9:0]];
`ifdef MEM_PARITY_EN
            e_pe[dn] = !oor && flip_mask != '0;
`endif
        end
        last_start = st;
        last_done  = dn;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = cyc; i < NC; i++) begin
                e_busy[i] = 0; e_ce[i] = 0; e_we[i] = 0; e_dv[i] = 0; e_wd[i] = 0; e_be[i] = 0; e_pe[i] = 0;
            end
            last_start = -1; last_done = -1; m_ovr = 0; m_data = '0; m_ar = '0;
        end
        if (e_dv[cyc]) m_data = e_rd[cyc];
        chk("data_valid", data_valid, e_dv[cyc]);
        chk("write_done", write_done, e_wd[cyc]);
        chk("bus_error", bus_error, e_be[cyc]);
        chk("busy", busy, e_busy[cyc]);
        chk("overrun", overrun, m_ovr);
        chk("sram_ce", sram_ce, e_ce[cyc]);
        chk("sram_we", sram_we, e_we[cyc]);
        chk("data_out", data_out, m_data);
`ifdef MEM_PARITY_EN
        chk("parity_error", parity_error, e_pe[cyc]);
`endif
        if (e_ce[cyc]) chk("sram_addr", sram_addr, e_ad[cyc]);
        if (e_we[cyc]) chk("sram_wdata", sram_wdata, e_wv[cyc]);
        if (reset && (load_mem || store_mem)) accept();
        if (reset && load_ar) m_ar = addr_in;
        cyc++;
    end

    task automatic sync(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic a_r, input logic [31:0] a, input logic ld, input logic st, input logic [31:0] d);
        load_ar = a_r; addr_in = a; load_mem = ld; store_mem = st; data_in = d;
        @(posedge clock);
        #1;
        load_ar = 0; load_mem = 0; store_mem = 0;
    endtask

    int          gap_t[7]  = '{0, 0, 8, 3, 8, 8, 8};
    logic        ar_t[7]   = '{1, 1, 1, 0, 1, 1, 1};
    logic [31:0] addr_t[7] = '{20, 20, 21, 0, 1023, 1025, 20};
    logic        ld_t[7]   = '{0, 1, 0, 1, 1, 0, 1};
    logic        st_t[7]   = '{1, 0, 1, 0, 0, 1, 0};
    logic [31:0] d_t[7]    = '{32'hA1A1A1A1, 0, 32'hB2B2B2B2, 0, 0, 32'h5, 0};

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = wide(init_val(i));
            mdl_mem[i]  = init_val(i);
        end
        load_ar = 0; load_mem = 0; store_mem = 0; addr_in = '0; data_in = '0;
        reset = 1;
        #1 reset = 0;
        wait_neg(1);
        chk("reset_data_out", data_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ce", sram_ce, 0);
        sync;
        reset = 1;
        sync;
        drive(1, 5, 0, 1, 32'hDEADBEEF);
        wait_neg(1);
        chk("t2_ce", sram_ce, 1);
        chk("t2_we", sram_we, 1);
        chk("t2_addr", sram_addr, 5);
        wait_neg(2);
        chk("t2_ce_last", sram_ce, 1);
        wait_neg(1);
        chk("t2_write_done", write_done, 1);
        sync;
        drive(0, 0, 1, 0, 0);
        wait_neg(4);
        chk("t2_read_valid", data_valid, 1);
        chk("t2_read_data", data_out, 32'hDEADBEEF);
        sync;
        drive(1, 7, 1, 0, 0);
        sync;
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            wait_neg(1);
            chk("t1_no_valid", data_valid, 0);
            chk("t1_busy", busy, 0);
            chk("t1_data_out", data_out, 0);
        end
        sync;
        reset = 1;
        drive(1, 7, 1, 0, 0);
        wait_neg(4);
        chk("t1_after_valid", data_valid, 1);
        chk("t1_after_data", data_out, init_val(7));
        sync;
        drive(1, 10, 1, 0, 0);
        drive(1, 11, 1, 0, 0);
        drive(1, 12, 0, 1, 32'h0BADF00D);
        wait_neg(1);
        chk("t3_overrun", overrun, 1);
        chk("t3_busy", busy, 1);
        wait_neg(5);
        chk("t3_pend_valid", data_valid, 1);
        chk("t3_pend_data", data_out, init_val(11));
        sync(3);
        for (int i = 0; i < 7; i++) begin
            if (gap_t[i] > 0) sync(gap_t[i]);
            drive(ar_t[i], addr_t[i], ld_t[i], st_t[i], d_t[i]);
        end
        sync(8);
        drive(1, 1024, 1, 0, 0);
        wait_neg(1);
        chk("t4_valid", data_valid, 1);
        chk("t4_bus_error", bus_error, 1);
        chk("t4_data", data_out, 0);
        chk("t4_no_ce", sram_ce, 0);
        sync(2);
        reset = 0;
        sync;
        reset = 1;
        drive(1, 3, 1, 1, 32'h12345678);
        wait_neg(1);
        chk("t5_we0", we0, 1);
        chk("t5_addr0", addr0, 3);
        chk("t5_overrun", overrun, 1);
        wait_neg(1);
        chk("t5_write_done0", wd0, 1);
        chk("t5_no_valid0", dv0, 0);
        chk("t5_overrun0", ovr0, 1);
        wait_neg(2);
        chk("t5_write_done", write_done, 1);
        sync(2);
        drive(0, 0, 1, 0, 0);
        wait_neg(4);
        chk("t5_read_back", data_out, 32'h12345678);
`ifdef MEM_PARITY_EN
        sync(2);
        flip_mask = BW'(1) << 32;
        drive(1, 5, 1, 0, 0);
        wait_neg(4);
        chk("t6_valid", data_valid, 1);
        chk("t6_parity_error", parity_error, 1);
        chk("t6_data", data_out, 32'hDEADBEEF);
        sync;
        flip_mask = '0;
`endif
        sync(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
